imm_decode_pipe: RTL and testbench
==================================

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, upstream instruction present.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts the upstream instruction.
REQ-006 The block SHALL have ports in_inst (input, 32, instruction) and in_pc (input, XLEN, its PC).
REQ-007 The block SHALL have port flush, input, 1, discards the held and incoming instruction.
REQ-008 The block SHALL have port out_valid, output, 1, decoded result present.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 The block SHALL have ports out_inst (output, 32) and out_pc (output, XLEN), registered copies of the inputs.
REQ-011 The block SHALL have port out_imm_type, output, 3: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
REQ-012 The block SHALL have port out_imm, output, XLEN, sign-extended immediate (zero-extended for Z).
REQ-013 The block SHALL have port out_illegal, output, 1, opcode not recognised.

Function
REQ-014 The block SHALL be a one-stage pipeline register: in_ready = !out_valid || out_ready.
REQ-015 A transfer SHALL occur when in_valid && in_ready; the decoded fields appear on the outputs the next cycle (latency 1).
REQ-016 Output payload SHALL be held stable while out_valid && !out_ready.
REQ-017 out_valid SHALL clear on the edge after an out handshake with no simultaneous input transfer.
REQ-018 Simultaneous out handshake and input transfer SHALL reload the register; out_valid stays 1 (full throughput, no bubble).
REQ-019 Opcodes 0010011, 0000011, 1100111 SHALL decode I: imm = sext(inst[31:20]).
REQ-020 Opcode 0011011 SHALL decode I when XLEN=64, else NONE with illegal=1.
REQ-021 Opcode 0100011 SHALL decode S: imm = sext({inst[31:25],inst[11:7]}).
REQ-022 Opcode 1100011 SHALL decode B: imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-023 Opcodes 0110111, 0010111 SHALL decode U: imm = sext({inst[31:12],12'b0}) to XLEN.
REQ-024 Opcode 1101111 SHALL decode J: imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-025 Opcodes 0110011, 0111011 (XLEN=64 only), 0001111, and 1110011 with inst[14]=0 SHALL decode NONE, imm=0, illegal=0.
REQ-026 Any other opcode SHALL decode NONE, imm=0, illegal=1.
REQ-027 flush SHALL take priority: next cycle out_valid=0 regardless of in_valid or out_ready; in_ready is unaffected combinationally.

Reset
REQ-028 While rst_n=0 the block SHALL force out_valid=0, out_imm_type=NONE, out_imm=0, out_inst=0, out_pc=0, out_illegal=0, asynchronously.
REQ-029 Reset asserted mid-transfer SHALL drop the held instruction; after release the block is empty with in_ready=1.

Configuration
REQ-030 With IMM_DECODE_ZICSR_EN defined, opcode 1110011 with inst[14]=1 SHALL decode Z: imm = zext(inst[19:15]).
REQ-031 Without IMM_DECODE_ZICSR_EN, that case SHALL decode NONE, imm=0, illegal=0; encoding Z=6 is never produced.

Structure
REQ-032 Imm-type encodings and opcode constants SHALL live in a shared package, imm_decode_pkg, reused by the controller.
REQ-033 Combinational decode SHALL be a sub-module imm_decode_comb (inst in; type, imm, illegal out), instantiated once ahead of the register.

Verification
REQ-034 The bench SHALL check: 0xFFF00093 (addi x1,x0,-1) -> type I, imm=0xFFFFFFFF, one cycle later.
REQ-035 The bench SHALL check: 0x00112623 -> S, imm=12; 0x00000463 -> B, imm=8; 0x123452B7 -> U, imm=0x12345000.
REQ-036 The bench SHALL check: 0xFFDFF06F (jal x0,-4) -> J, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
REQ-037 The bench SHALL check: 0x3002D073 (csrrwi) -> Z, imm=5 with macro; NONE, imm=0 without.
REQ-038 The bench SHALL check: out_ready=0 for 3 cycles with in_valid=1 -> payload stable, in_ready=0; then back-to-back stream -> one result per cycle.
REQ-039 The bench SHALL check: flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; rst_n pulse mid-stall -> all outputs zero immediately.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared immediate-type encodings, RV opcode constants and pipe states for the
// immediate decode pipeline.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } pipe_state_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // 32-bit immediate before widening to XLEN; Z is built with bit 31 clear so
  // a later sign extension leaves it zero-extended.
  function automatic logic [31:0] raw_imm(input imm_type_e t, input logic [31:0] inst);
    logic [31:0] r;
    case (t)
      IMM_I:   r = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   r = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   r = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   r = {inst[31:12], 12'b0};
      IMM_J:   r = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   r = {27'b0, inst[19:15]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational opcode classification and immediate extraction.
// Optional feature: IMM_DECODE_ZICSR_EN enables the Z (CSR zimm) immediate.
module imm_decode_comb
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output imm_type_e       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] raw;

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_type = IMM_I;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) imm_type = IMM_I;
        else            illegal  = 1'b1;
      end
      OPC_STORE:            imm_type = IMM_S;
      OPC_BRANCH:           imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:   imm_type = IMM_U;
      OPC_JAL:              imm_type = IMM_J;
      OPC_OP, OPC_MISC_MEM: imm_type = IMM_NONE;
      OPC_OP_32:            illegal  = (XLEN != 64);
      OPC_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
        if (inst[14]) imm_type = IMM_Z;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

  assign raw = raw_imm(imm_type, inst);
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_decode_pipe.sv
// One-stage valid/ready pipeline register holding the decoded immediate.
// Optional feature: IMM_DECODE_ZICSR_EN (passed through to imm_decode_comb).
module imm_decode_pipe
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imm_type,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  imm_type_e       dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  pipe_state_e     state_q;
  pipe_state_e     state_d;
  logic            load;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_dec (
    .inst     (in_inst),
    .imm_type (dec_type),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  // flush suppresses the capture but leaves in_ready purely a function of the output side
  assign load      = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    if (flush)                       state_d = ST_EMPTY;
    else if (load)                   state_d = ST_FULL;
    else if (out_valid && out_ready) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst     <= '0;
      out_pc       <= '0;
      out_imm_type <= IMM_NONE;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
    end else if (load) begin
      out_inst     <= in_inst;
      out_pc       <= in_pc;
      out_imm_type <= dec_type;
      out_imm      <= dec_imm;
      out_illegal  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: decode table, latency, backpressure,
// flush and asynchronous reset behaviour.
module tb_imm_decode_pipe;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_imm_type;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  imm_decode_pipe #(
    .XLEN(XLEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_imm_type (out_imm_type),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  ty;
    logic [31:0] imm32;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      ty;
    logic [XLEN-1:0] imm;
    logic            ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  vec_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic init_vectors();
    vecs.push_back('{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0}); // addi x1,x0,-1
    vecs.push_back('{32'h00112623, 3'd2, 32'h0000000C, 1'b0}); // sw 12
    vecs.push_back('{32'h00000463, 3'd3, 32'h00000008, 1'b0}); // beq +8
    vecs.push_back('{32'h123452B7, 3'd4, 32'h12345000, 1'b0}); // lui
    vecs.push_back('{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 1'b0}); // jal -4
`ifdef IMM_DECODE_ZICSR_EN
    vecs.push_back('{32'h3002D073, 3'd6, 32'h00000005, 1'b0}); // csrrwi zimm=5
`else
    vecs.push_back('{32'h3002D073, 3'd0, 32'h00000000, 1'b0});
`endif
    vecs.push_back('{32'h30029073, 3'd0, 32'h00000000, 1'b0}); // csrrw
    vecs.push_back('{32'h00000073, 3'd0, 32'h00000000, 1'b0}); // ecall
    vecs.push_back('{32'h00000033, 3'd0, 32'h00000000, 1'b0}); // add
    vecs.push_back('{32'h0000000F, 3'd0, 32'h00000000, 1'b0}); // fence
    vecs.push_back('{32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b1}); // bad opcode
    vecs.push_back('{32'h80002003, 3'd1, 32'hFFFFF800, 1'b0}); // lw -2048
    vecs.push_back('{32'h7FF00067, 3'd1, 32'h000007FF, 1'b0}); // jalr +2047
    vecs.push_back('{32'hFE000FE3, 3'd3, 32'hFFFFFFFE, 1'b0}); // branch -2
    vecs.push_back('{32'hFE000FA3, 3'd2, 32'hFFFFFFFF, 1'b0}); // store -1
    vecs.push_back('{32'h7FFFF0EF, 3'd5, 32'h000FFFFE, 1'b0}); // jal max positive
    vecs.push_back('{32'h00000017, 3'd4, 32'h00000000, 1'b0}); // auipc 0
    vecs.push_back('{32'h0000001B, (XLEN == 64) ? 3'd1 : 3'd0, 32'h0, (XLEN != 64)}); // addiw
    vecs.push_back('{32'h0000003B, 3'd0, 32'h0, (XLEN != 64)}); // addw
  endtask

  function automatic logic [XLEN-1:0] rand_pc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[1:0] = 2'b00;
    return XLEN'(r);
  endfunction

  task automatic drive_vec(input int k);
    cur      = vecs[k];
    in_inst  = cur.inst;
    in_pc    = rand_pc();
    in_valid = 1'b1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.inst = cur.inst;
    e.pc   = in_pc;
    e.ty   = cur.ty;
    e.imm  = XLEN'($signed(cur.imm32));
    e.ill  = cur.ill;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_imm_type !== 3'd0) begin n_fail++; $display("FAIL reset_type: got %0d expected 0", out_imm_type); end
    n_checks++; if (out_imm !== '0)        begin n_fail++; $display("FAIL reset_imm: got %h expected 0", out_imm); end
    n_checks++; if (out_inst !== '0)       begin n_fail++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
    n_checks++; if (out_pc !== '0)         begin n_fail++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_illegal !== 1'b0)  begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", out_illegal); end
    n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [XLEN-1:0] pc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_vec(0);
    pc = in_pc;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_imm_type !== 3'd1 || out_imm !== {XLEN{1'b1}} ||
        out_inst !== 32'hFFF00093 || out_pc !== pc || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_addi: got valid=%b type=%0d imm=%h inst=%h pc=%h ill=%b, expected 1 1 all-ones FFF00093 %h 0",
               out_valid, out_imm_type, out_imm, out_inst, out_pc, out_illegal, pc);
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int nv;
    logic exp_v;
    nv = vecs.size();
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_vec(0);
    for (int c = 0; c < nv + 2; c++) begin
      @(negedge clk);
      exp_v = (c >= 1 && c <= nv);
      n_checks++;
      if (out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_result c=%0d: got unexpected result inst=%h, expected none", c, out_inst);
        end else begin
          if (out_inst !== sb[0].inst || out_pc !== sb[0].pc || out_imm_type !== sb[0].ty ||
              out_imm !== sb[0].imm || out_illegal !== sb[0].ill) begin
            n_fail++;
            $display("FAIL b2b_result: got inst=%h pc=%h type=%0d imm=%h ill=%b, expected inst=%h pc=%h type=%0d imm=%h ill=%b",
                     out_inst, out_pc, out_imm_type, out_imm, out_illegal,
                     sb[0].inst, sb[0].pc, sb[0].ty, sb[0].imm, sb[0].ill);
          end
          void'(sb.pop_front());
        end
      end
      if (in_valid) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      if (in_valid && in_ready) push_exp();
      @(posedge clk); #1;
      if (c + 1 < nv) drive_vec(c + 1);
      else            in_valid = 1'b0;
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int nv;
    int idx;
    int stalls;
    logic accepted;
    nv = vecs.size();
    idx = 0;
    stalls = 0;
    sb.delete();
    @(posedge clk); #1;
    drive_vec(0);
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (idx >= nv && sb.size() == 0) break;
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL bp_result c=%0d: got unexpected result inst=%h, expected none", c, out_inst);
        end else if (out_inst !== sb[0].inst || out_pc !== sb[0].pc || out_imm_type !== sb[0].ty ||
                     out_imm !== sb[0].imm || out_illegal !== sb[0].ill) begin
          n_fail++;
          $display("FAIL bp_result c=%0d: got inst=%h pc=%h type=%0d imm=%h ill=%b, expected inst=%h pc=%h type=%0d imm=%h ill=%b",
                   c, out_inst, out_pc, out_imm_type, out_imm, out_illegal,
                   sb[0].inst, sb[0].pc, sb[0].ty, sb[0].imm, sb[0].ill);
        end
        if (!out_ready) begin
          stalls++;
          n_checks++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
        end else if (sb.size() != 0) begin
          void'(sb.pop_front());
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) push_exp();
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < nv) drive_vec(idx);
        else          in_valid = 1'b0;
      end
      if (c + 1 >= 1 && c + 1 <= 3) out_ready = 1'b0;
      else if (c + 1 < 8)           out_ready = 1'b1;
      else                          out_ready = 1'($urandom_range(0, 1));
    end
    n_checks++;
    if (idx != nv || sb.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got accepted=%0d pending=%0d, expected accepted=%0d pending=0", idx, sb.size(), nv);
    end
    n_checks++;
    if (stalls < 3) begin n_fail++; $display("FAIL bp_stalls: got %0d stall cycles expected at least 3", stalls); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      flush = 1'b0;
      drive_vec(1);
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_load k=%0d: got %b expected 1", k, out_valid); end
      drive_vec(2);
      flush = 1'b1;
      out_ready = (k == 1);
      #1;
      n_checks++;
      if (in_ready !== (k == 1)) begin n_fail++; $display("FAIL flush_in_ready k=%0d: got %b expected %b", k, in_ready, (k == 1)); end
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid k=%0d: got %b expected 0", k, out_valid); end
    end
    drive_vec(3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive_vec(4);
    @(posedge clk); #1;
    drive_vec(0);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall_setup: got valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_imm_type !== 3'd0 || out_imm !== '0 || out_inst !== '0 ||
        out_pc !== '0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b type=%0d imm=%h inst=%h pc=%h ill=%b expected all zero",
               out_valid, out_imm_type, out_imm, out_inst, out_pc, out_illegal);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== '0) begin
      n_fail++; $display("FAIL rst_release: got valid=%b in_ready=%b inst=%h expected 0 1 0", out_valid, in_ready, out_inst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_vectors();
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
